// File: rtl/calc_disp_pkg.sv
// Shared display types and glyph helpers for the MiniCalculator display back end.
package calc_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef struct packed {
        logic        err;
        logic        lzb;
        logic [15:0] data;
    } disp_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Glyph for one digit slot: error text wins over blanking, blanking wins over hex.
module seg_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic [1:0] dig,
    input  logic       blank,
    input  logic       err,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex2seg(nib);
        if (err) begin
            case (dig)
                2'd3:    seg = SEG_BLANK;
                2'd2:    seg = SEG_E;
                default: seg = SEG_R;
            endcase
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-synchronous value update.
module seg_scan
    import calc_disp_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int CNT_W   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [15:0] data_i,
    input  logic        err_i,
    input  logic        lzb_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        pend_o,
    output logic        frame_o
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic             tick;
    logic             boundary;
    logic             pend;
    disp_t            pnd;
    disp_t            act;
    disp_t            act_nxt;
    logic [15:0]      upper;
    logic             blank;
    logic [6:0]       glyph;

    assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
    assign boundary = tick && (idx == 2'd3);
    assign idx_nxt  = idx + 2'd1;

    // The slot about to be shown must see the word that will be active in its frame.
    assign act_nxt = (boundary && pend) ? pnd : act;
    assign upper   = act_nxt.data >> {idx_nxt, 2'b00};
    assign blank   = act_nxt.lzb && (idx_nxt != 2'd0) && (upper == 16'h0000);

    seg_decode u_dec (
        .nib   (upper[3:0]),
        .dig   (idx_nxt),
        .blank (blank),
        .err   (act_nxt.err),
        .seg   (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd3;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx_nxt;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pnd  <= '0;
            act  <= '0;
            pend <= 1'b0;
        end else begin
            act <= act_nxt;
            if (valid_i) begin
                pnd  <= '{err: err_i, lzb: lzb_i, data: data_i};
                pend <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_o  <= 4'b1111;
            seg_o <= SEG_BLANK;
        end else if (tick) begin
            an_o  <= ~(4'b0001 << idx_nxt);
            seg_o <= glyph;
        end
    end

    assign pend_o  = pend;
    assign frame_o = boundary;

endmodule
